// File: rtl/display_msg_scheduler.sv
// display_msg_scheduler
// Chooses which text message the seven-segment driver shows: the password
// prompt, or one of the transient messages ok / err / tmo. Event pulses are
// latched into a one-deep-per-type pending mask. The transient messages are
// prioritised err > tmo > ok, and any transient beats the password prompt.
// Each transient stays on screen for HOLD_SECS seconds unless it is acked,
// preempted or cleared. All outputs are registered and are computed from the
// next-state values, so they follow the causing input by one clock.
//
// Type vectors are one-hot, laid out as {err, tmo, ok}. With this layout the
// bit position is also the priority, so a larger numeric value always means
// a higher-priority type.

module display_msg_scheduler #(
  parameter int HOLD_SECS = 3,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1s,
  input  logic       req_pwd,
  input  logic       evt_ok,
  input  logic       evt_err,
  input  logic       evt_tmo,
  input  logic       ack,
  input  logic       clear,
  output logic       show_pwd,
  output logic       show_ok,
  output logic       show_err,
  output logic       show_tmo,
  output logic [2:0] msg_code,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PWD  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_SECS - 1);

  state_t           state_reg, state_next;
  logic [2:0]       cur_reg, cur_next;      // one-hot type being shown
  logic [2:0]       pend_reg, pend_next;    // pending types, never holds cur
  logic [CNT_W-1:0] cnt_reg, cnt_next;      // whole seconds already shown

  logic [2:0]       new_evt;
  logic [2:0]       cand;
  logic [2:0]       cand_top;
  logic [2:0]       new_top;
  logic             expire;
  state_t           rest_state;

  // Keep only the highest-priority bit of a type vector.
  function automatic logic [2:0] top_bit(input logic [2:0] v);
    logic [2:0] r;
    if (v[2])      r = 3'b100;
    else if (v[1]) r = 3'b010;
    else if (v[0]) r = 3'b001;
    else           r = 3'b000;
    return r;
  endfunction

  // Event capture and the values the selection logic works from.
  always_comb begin
    new_evt    = {evt_err, evt_tmo, evt_ok};
    cand       = pend_reg | new_evt;
    cand_top   = top_bit(cand);
    new_top    = top_bit(new_evt);
    // The hold ends on the tick that would bring the count to HOLD_SECS.
    expire     = ack | (tick_1s & (cnt_reg == LAST_CNT));
    rest_state = req_pwd ? ST_PWD : ST_IDLE;
  end

  // Next-state logic. Clear beats everything; expiry (timed or acked) beats
  // preemption, so a message whose time is up is dropped, not requeued.
  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    pend_next  = pend_reg;
    cnt_next   = cnt_reg;

    if (clear) begin
      // Events arriving alongside clear are discarded on purpose.
      state_next = rest_state;
      cur_next   = 3'b000;
      pend_next  = 3'b000;
      cnt_next   = '0;
    end else if (state_reg != ST_SHOW || expire) begin
      // Entry from IDLE/PWD and the end of a hold share one selection rule.
      if (cand != 3'b000) begin
        state_next = ST_SHOW;
        cur_next   = cand_top;
        pend_next  = cand & ~cand_top;
        cnt_next   = '0;
      end else begin
        state_next = rest_state;
        cur_next   = 3'b000;
        pend_next  = 3'b000;
        cnt_next   = '0;
      end
    end else if (new_top > cur_reg) begin
      // Preemption: the interrupted message goes back into the pending set
      // and will get a fresh hold when it is shown again.
      cur_next  = new_top;
      pend_next = (pend_reg | new_evt | cur_reg) & ~new_top;
      cnt_next  = '0;
    end else begin
      // Lower-priority arrivals coalesce into pending; a repeat of the
      // current type restarts its hold and ignores a coincident tick.
      pend_next = (pend_reg | new_evt) & ~cur_reg;
      if ((new_evt & cur_reg) != 3'b000) begin
        cnt_next = '0;
      end else if (tick_1s) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cur_reg   <= 3'b000;
      pend_reg  <= 3'b000;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      pend_reg  <= pend_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Registered driver outputs, decoded from the next state so the display
  // reacts on the edge right after the causing input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      show_pwd <= 1'b0;
      show_ok  <= 1'b0;
      show_err <= 1'b0;
      show_tmo <= 1'b0;
      msg_code <= 3'd0;
      busy     <= 1'b0;
    end else begin
      show_pwd <= (state_next == ST_PWD);
      show_ok  <= (state_next == ST_SHOW) & cur_next[0];
      show_tmo <= (state_next == ST_SHOW) & cur_next[1];
      show_err <= (state_next == ST_SHOW) & cur_next[2];
      if (state_next == ST_PWD)       msg_code <= 3'd1;
      else if (state_next != ST_SHOW) msg_code <= 3'd0;
      else if (cur_next[2])           msg_code <= 3'd3;
      else if (cur_next[1])           msg_code <= 3'd4;
      else                            msg_code <= 3'd2;
      busy <= (state_next == ST_SHOW) | (pend_next != 3'b000);
    end
  end

endmodule

// File: tb/tb_display_msg_scheduler.sv
// Bench for display_msg_scheduler: a hand-derived vector table covering the
// documented scenarios, an asynchronous reset check, then random stimulus
// compared against a countdown-style reference model.

module tb_display_msg_scheduler;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1s = 1'b0;
  logic       req_pwd = 1'b0;
  logic       evt_ok = 1'b0;
  logic       evt_err = 1'b0;
  logic       evt_tmo = 1'b0;
  logic       ack = 1'b0;
  logic       clear = 1'b0;
  logic       show_pwd, show_ok, show_err, show_tmo;
  logic [2:0] msg_code;
  logic       busy;

  int n_vec = 0;
  int n_mis = 0;

  display_msg_scheduler #(.HOLD_SECS(HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .req_pwd(req_pwd),
    .evt_ok(evt_ok), .evt_err(evt_err), .evt_tmo(evt_tmo), .ack(ack),
    .clear(clear), .show_pwd(show_pwd), .show_ok(show_ok),
    .show_err(show_err), .show_tmo(show_tmo), .msg_code(msg_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: message codes 0 none, 1 pwd, 2 ok, 3 err, 4 tmo.
  // m_left counts the seconds still to be shown.
  int m_cur = 0;
  bit m_pend[5];
  int m_left = 0;

  function automatic int rank(input int code);
    case (code)
      3: return 3;
      4: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int best(input bit s[5]);
    if (s[3]) return 3;
    if (s[4]) return 4;
    if (s[2]) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_cur = 0;
    m_left = 0;
    for (int i = 0; i < 5; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input bit r, o, e, t, a, c, k);
    bit nw[5];
    bit all[5];
    int b;
    for (int i = 0; i < 5; i++) nw[i] = 1'b0;
    nw[2] = o; nw[3] = e; nw[4] = t;
    for (int i = 0; i < 5; i++) all[i] = m_pend[i] | nw[i];
    if (c) begin
      model_reset();
      m_cur = r ? 1 : 0;
    end else if (m_cur < 2 || a || (k && m_left == 1)) begin
      b = best(all);
      if (b != 0) begin
        m_cur = b;
        m_left = HOLD;
        for (int i = 0; i < 5; i++) m_pend[i] = all[i];
        m_pend[b] = 1'b0;
      end else begin
        m_cur = r ? 1 : 0;
      end
    end else if (rank(best(nw)) > rank(m_cur)) begin
      b = best(nw);
      for (int i = 0; i < 5; i++) m_pend[i] = all[i];
      m_pend[m_cur] = 1'b1;
      m_pend[b] = 1'b0;
      m_cur = b;
      m_left = HOLD;
    end else begin
      for (int i = 2; i < 5; i++) if (nw[i] && i != m_cur) m_pend[i] = 1'b1;
      if (nw[m_cur]) m_left = HOLD;
      else if (k) m_left = m_left - 1;
    end
  endtask

  function automatic bit model_busy();
    return (m_cur >= 2) || m_pend[2] || m_pend[3] || m_pend[4];
  endfunction

  task automatic check(input string nm, input logic [2:0] ec, input bit eb);
    logic [3:0] es;
    es = {ec == 3'd4, ec == 3'd3, ec == 3'd2, ec == 3'd1};
    n_vec++;
    if (msg_code !== ec || busy !== eb ||
        {show_tmo, show_err, show_ok, show_pwd} !== es) begin
      n_mis++;
      $display("FAIL %s: got code=%0d busy=%0b show(tmo,err,ok,pwd)=%b, want code=%0d busy=%0b show=%b",
               nm, msg_code, busy, {show_tmo, show_err, show_ok, show_pwd}, ec, eb, es);
    end else begin
      $display("ok   %s: code=%0d busy=%0b", nm, msg_code, busy);
    end
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // leave the bench 1 time unit after the edge ready to sample.
  task automatic cycle(input bit r, o, e, t, a, c, k);
    @(negedge clk);
    req_pwd = r; evt_ok = o; evt_err = e; evt_tmo = t;
    ack = a; clear = c; tick_1s = k;
    @(posedge clk);
    model_step(r, o, e, t, a, c, k);
    #1;
  endtask

  typedef struct {
    bit         r, o, e, t, a, c, k;
    logic [2:0] code;
    bit         busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, o, e, t, a, c, k, input logic [2:0] code, input bit b);
    vec_t v;
    v.r = r; v.o = o; v.e = e; v.t = t; v.a = a; v.c = c; v.k = k;
    v.code = code; v.busy = b;
    vecs.push_back(v);
  endtask

  initial begin
    //     r  o  e  t  a  c  k   code busy
    // ok held three ticks
    add(0, 1, 0, 0, 0, 0, 0, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd0, 0);
    // password prompt, err beats it, prompt returns
    add(1, 0, 0, 0, 0, 0, 0, 3'd1, 0);
    add(1, 0, 1, 0, 0, 0, 0, 3'd3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 3'd3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 3'd3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 3'd1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    // preemption: ok, one tick, err, then ok gets a full hold
    add(0, 1, 0, 0, 0, 0, 0, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3'd3, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd3, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd3, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd0, 0);
    // all three at once: err, tmo, ok
    add(0, 1, 1, 1, 0, 0, 0, 3'd3, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd3, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd3, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd0, 0);
    // retrigger of tmo after two ticks
    add(0, 0, 0, 1, 0, 0, 0, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
    add(0, 0, 0, 1, 0, 0, 0, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3'd0, 0);
    // ack with ok pending, then ack ok
    add(0, 0, 0, 1, 0, 0, 0, 3'd4, 1);
    add(0, 1, 0, 0, 0, 0, 0, 3'd4, 1);
    add(0, 0, 0, 0, 1, 0, 0, 3'd2, 1);
    add(0, 0, 0, 0, 1, 0, 0, 3'd0, 0);
    // clear with tmo pending; ack ignored in IDLE; event with clear dropped
    add(0, 0, 1, 1, 0, 0, 0, 3'd3, 1);
    add(0, 0, 0, 0, 0, 1, 0, 3'd0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 3'd0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 3'd0, 0);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset", 3'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].o, vecs[i].e, vecs[i].t, vecs[i].a, vecs[i].c, vecs[i].k);
      check($sformatf("vec%0d", i), vecs[i].code, vecs[i].busy);
    end

    // Asynchronous reset in the middle of a SHOW hold.
    cycle(0, 0, 1, 0, 0, 0, 0);
    check("pre_areset", 3'd3, 1'b1);
    @(negedge clk);
    tick_1s = 1'b0; evt_err = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 3'd0, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Random stimulus against the model.
    begin
      bit r;
      r = 1'b0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 19) == 0) r = ~r;
        cycle(r,
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 13) == 0,
              $urandom_range(0, 12) == 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 2) == 0);
        check($sformatf("rnd%0d", n), 3'(m_cur), model_busy());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/display_msg_scheduler.md
Name: display_msg_scheduler

Overview:
- Decides which text message the 4-digit seven-segment display shows: password prompt ("PASS"), "OK", "Err" or "tMO"; otherwise the normal time/alarm digits.
- Drives the driver's one-hot show_pwd/show_ok/show_err/show_tmo inputs.
- Event pulses from the password/alarm logic are latched and prioritised. Each transient message is held for a fixed number of seconds.
- When the current message ends, the highest-priority pending message is shown next.

Parameters:
- HOLD_SECS, 3, number of tick_1s pulses each transient message (ok/err/tmo) stays on screen; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_SECS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick_1s  in  1  one-cycle pulse, once per second
- req_pwd  in  1  level; password entry active, request "PASS"
- evt_ok  in  1  one-cycle pulse; password accepted
- evt_err  in  1  one-cycle pulse; password rejected
- evt_tmo  in  1  one-cycle pulse; entry timed out
- ack  in  1  one-cycle pulse; user dismisses current transient message
- clear  in  1  one-cycle pulse; discard current and pending messages
- show_pwd  out  1  registered; to display driver
- show_ok  out  1  registered; to display driver
- show_err  out  1  registered; to display driver
- show_tmo  out  1  registered; to display driver
- msg_code  out  3  registered; 0 none, 1 pwd, 2 ok, 3 err, 4 tmo
- busy  out  1  registered; transient shown or pending

Behaviour:
- Reset (reset_n low, asynchronous):
  - All show_* = 0, msg_code = 0, busy = 0.
  - State IDLE, pending mask = 3'b000, hold counter = 0.
- Output rules:
  - At most one show_* is high in any cycle.
  - msg_code always matches show_*.
  - All outputs are updated on the clock edge after the causing input (1-cycle latency).
- States:
  - IDLE: no message shown.
  - PWD: show_pwd high.
  - SHOW: one transient shown; type held in cur register.
- Priority: err > tmo > ok. A transient always beats pwd.
- Event capture, each cycle:
  - new = {evt_err, evt_tmo, evt_ok}.
  - cand = pending | new.
- IDLE/PWD:
  - If cand != 0: go to SHOW with cur = highest bit of cand, clear that bit from pending, keep the other bits pending, load counter = 0.
  - Otherwise: state = PWD if req_pwd, else IDLE. PWD follows req_pwd with 1-cycle latency.
- SHOW, new event of the same type as cur: retrigger; counter reloads to 0, no pending change.
- SHOW, higher-priority new event: preempt.
  - cur becomes the new type and the counter reloads.
  - The preempted type is set in pending.
- SHOW, lower-priority new event: set its pending bit. Setting an already-set bit has no effect.
- Hold counting:
  - Counter increments on each tick_1s in SHOW. A tick in the entry or retrigger cycle is not counted.
  - Expiry occurs in the cycle where the counter would reach HOLD_SECS.
  - On expiry, select the highest bit of cand (this includes events arriving in the expiry cycle) exactly as from IDLE.
  - If cand == 0, go to PWD/IDLE per req_pwd.
- ack in SHOW: treated as immediate expiry, with the same selection rules. ack in IDLE/PWD is ignored.
- clear:
  - Highest priority of all inputs.
  - pending = 0 and counter = 0; next state is PWD if req_pwd, else IDLE.
  - Events arriving in the same cycle as clear are dropped.
- busy = (state == SHOW) | (pending != 0).
- req_pwd dropping while in SHOW has no effect on the transient message.
- The pending mask never contains the bit of cur. Pending depth is 1 per type, so repeated events coalesce.

Test Plan:
- Reset with HOLD_SECS=3: pulse evt_ok, then 3 tick_1s → show_ok=1, msg_code=2 from the cycle after the pulse; cleared on the cycle after the 3rd tick; busy goes 1→0.
- req_pwd=1 while IDLE → show_pwd=1 next cycle. Then evt_err → show_err=1, show_pwd=0. After 3 ticks → show_pwd=1 again, msg_code=1.
- Preemption: evt_ok, then after 1 tick evt_err → show_err for a full 3 ticks, then show_ok for a full 3 ticks (counter reloaded), then IDLE.
- Simultaneous evt_ok, evt_tmo, evt_err in one cycle → shown in order err, tmo, ok, each for 3 ticks. busy stays 1 throughout and drops after ok expires.
- Retrigger and ack:
  - evt_tmo, 2 ticks, evt_tmo again → 3 more ticks needed before expiry.
  - ack during show_tmo with ok pending → show_ok the next cycle.
- clear while showing err with tmo pending, req_pwd=0 → all show_* = 0 and busy = 0 next cycle. Assert reset_n low mid-SHOW → outputs 0 immediately, without waiting for a clock edge.
